// File: rtl/axis_packet_gen.sv
// AXI-Stream packet burst generator: emits pkt_num packets of pkt_len bytes separated by gap idle cycles.
// Optional macro PKTGEN_PRBS_EN replaces the incrementing payload with a replicated 32-bit LFSR.
module axis_packet_gen #(
  parameter int DW    = 512,
  parameter int GAP_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [15:0]       pkt_len,
  input  logic [15:0]       pkt_num,
  input  logic [GAP_W-1:0]  gap,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkts_sent,
  output logic [DW-1:0]     axis_out_tdata,
  output logic [DW/8-1:0]   axis_out_tkeep,
  output logic              axis_out_tlast,
  output logic              axis_out_tvalid,
  input  logic              axis_out_tready
);

  localparam int               BPB     = DW / 8;
  localparam logic [15:0]      BPB16   = 16'(BPB);
  localparam logic [7:0]       BPB8    = 8'(BPB);
  localparam logic [GAP_W-1:0] GAP_ONE = 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           r_state, w_next;
  logic [15:0]      r_len, r_num, r_rem, r_pkts;
  logic [7:0]       r_off;
  logic [GAP_W-1:0] r_gap, r_gcnt;
  logic             w_xfer, w_last;
  logic [15:0]      w_pkts_nxt, w_len_eff;

  assign w_xfer     = axis_out_tvalid & axis_out_tready;
  assign w_last     = (r_rem <= BPB16);
  assign w_pkts_nxt = r_pkts + 16'd1;
  assign w_len_eff  = (pkt_len == 16'd0) ? 16'd1 : pkt_len;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = (pkt_num == 16'd0) ? DONE : SEND;
      SEND: if (w_xfer && w_last) begin
        if (w_pkts_nxt == r_num)  w_next = DONE;
        else if (r_gap != '0)     w_next = GAP;
      end
      GAP:  if (r_gcnt == GAP_ONE) w_next = SEND;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_rem counts bytes still owed in the current packet; r_off is the payload byte offset mod 256
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pkts <= 16'd0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_len  <= w_len_eff;
          r_rem  <= w_len_eff;
          r_off  <= 8'd0;
          r_num  <= pkt_num;
          r_gap  <= gap;
          r_pkts <= 16'd0;
        end
        SEND: if (w_xfer) begin
          if (w_last) begin
            r_pkts <= w_pkts_nxt;
            r_rem  <= r_len;
            r_off  <= 8'd0;
            r_gcnt <= r_gap;
          end else begin
            r_rem  <= r_rem - BPB16;
            r_off  <= r_off + BPB8;
          end
        end
        GAP:  r_gcnt <= r_gcnt - GAP_ONE;
        default: ;
      endcase
    end
  end

`ifdef PKTGEN_PRBS_EN
  logic [31:0] r_lfsr;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn || (r_state == IDLE && start)) r_lfsr <= 32'hFFFF_FFFF;
    else if (w_xfer)                           r_lfsr <= lfsr_step(r_lfsr);
  end
`endif

  assign axis_out_tvalid = (r_state == SEND);
  assign axis_out_tlast  = axis_out_tvalid & w_last;
  assign busy            = (r_state != IDLE);
  assign done            = (r_state == DONE);
  assign pkts_sent       = r_pkts;

  always_comb begin
    axis_out_tkeep = '0;
    axis_out_tdata = '0;
    if (axis_out_tvalid) begin
      for (int j = 0; j < BPB; j++) begin
        axis_out_tkeep[j] = (16'(j) < r_rem);
        if (axis_out_tkeep[j]) begin
`ifdef PKTGEN_PRBS_EN
          axis_out_tdata[8*j +: 8] = r_lfsr[8*(j%4) +: 8];
`else
          axis_out_tdata[8*j +: 8] = r_off + 8'(j);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_gen.sv
// Randomized bench for axis_packet_gen: a queue of expected beats built from the packet rules
// is compared against every valid beat, along with gap length, done timing and pkts_sent.
module tb_axis_packet_gen;

  localparam int DW  = 512;
  localparam int BPB = DW / 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic [15:0]     pkt_len = '0, pkt_num = '0;
  logic [7:0]      gap = '0;
  logic            busy, done;
  logic [15:0]     pkts_sent;
  logic [DW-1:0]   tdata;
  logic [BPB-1:0]  tkeep;
  logic            tlast, tvalid;
  logic            tready = 1'b1;

  axis_packet_gen #(.DW(DW), .GAP_W(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .pkt_len(pkt_len), .pkt_num(pkt_num),
    .gap(gap), .busy(busy), .done(done), .pkts_sent(pkts_sent),
    .axis_out_tdata(tdata), .axis_out_tkeep(tkeep), .axis_out_tlast(tlast),
    .axis_out_tvalid(tvalid), .axis_out_tready(tready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [BPB-1:0] keep;
    logic           last;
    logic [DW-1:0]  data;
    int             pkt;
    bit             first;
  } beat_t;

  beat_t exp_q[$];
  beat_t b;
  int    g_gap = 0;
  int    idle_cnt = 0;
  int    ncyc = 0;
  int    last_xfer_n = 0;
  bit    mon_en = 1'b1;
  int    rdy_mode = 0;

  // Expected beats: each packet is ceil(len/BPB) beats, byte k of the packet carries k mod 256
  task automatic build(input int len, input int num);
    int n_len;
`ifdef PKTGEN_PRBS_EN
    logic [31:0] m = 32'hFFFF_FFFF;
`endif
    n_len = (len == 0) ? 1 : len;
    for (int p = 0; p < num; p++) begin
      for (int bi = 0; bi * BPB < n_len; bi++) begin
        beat_t e;
        int left;
        left    = n_len - bi * BPB;
        e.keep  = '0;
        e.data  = '0;
        e.last  = (left <= BPB);
        e.pkt   = p;
        e.first = (bi == 0);
        for (int j = 0; j < BPB; j++) begin
          if (j < left) begin
            e.keep[j] = 1'b1;
`ifdef PKTGEN_PRBS_EN
            e.data[8*j +: 8] = m[8*(j%4) +: 8];
`else
            e.data[8*j +: 8] = 8'((bi * BPB + j) % 256);
`endif
          end
        end
`ifdef PKTGEN_PRBS_EN
        m = {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]};
`endif
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (mon_en && resetn) begin
      if (tvalid) begin
        if (exp_q.size() == 0) check("extra_beat", tvalid, 1'b0);
        else begin
          b = exp_q[0];
          if (b.first && b.pkt > 0) check("gap_len", idle_cnt, g_gap);
          check("tkeep", tkeep, b.keep);
          check("tlast", tlast, b.last);
          check("tdata", tdata, b.data);
          if (tready) begin
            void'(exp_q.pop_front());
            if (tlast) begin
              idle_cnt    = 0;
              last_xfer_n = ncyc;
            end
          end
        end
      end else idle_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       tready = 1'b1;
      1:       tready = ~tready;
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic run_burst(input int len, input int num, input int gp, input int mode);
    int i;
    rdy_mode = mode;
    g_gap    = gp;
    build(len, num);
    @(posedge clk); #2;
    start   = 1'b1;
    pkt_len = 16'(len);
    pkt_num = 16'(num);
    gap     = 8'(gp);
    @(posedge clk); #2;
    start   = 1'b0;
    pkt_len = 16'($urandom);
    pkt_num = 16'($urandom);
    gap     = 8'($urandom);
    @(negedge clk); #1;
    if (num == 0) begin
      check("zero_done", done, 1'b1);
      check("zero_tvalid", tvalid, 1'b0);
    end else begin
      check("first_tvalid", tvalid, 1'b1);
    end
    for (i = 0; i < 4000 && !done; i++) begin
      @(negedge clk); #1;
    end
    check("done_seen", done, 1'b1);
    if (num > 0) check("done_lat", ncyc - last_xfer_n, 1);
    check("pkts_sent", pkts_sent, num);
    check("beats_left", exp_q.size(), 0);
    check("busy_done", busy, 1'b1);
    @(negedge clk); #1;
    check("done_pulse", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("pkts_hold", pkts_sent, num);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tkeep", tkeep, '0);
    check("rst_tdata", tdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pkts", pkts_sent, 16'd0);
    @(posedge clk); #2;
    resetn = 1'b1;

    run_burst(130, 1, 0, 0);
    run_burst(64, 3, 0, 0);
    run_burst(1, 2, 4, 0);
    run_burst(256, 1, 0, 1);
    run_burst(0, 2, 1, 0);
    run_burst(100, 0, 3, 0);

    // Reset while beat 2 of a 3-beat packet is on the bus
    rdy_mode = 0;
    build(130, 1);
    g_gap = 0;
    @(posedge clk); #2;
    start = 1'b1; pkt_len = 16'd130; pkt_num = 16'd1; gap = 8'd0;
    @(posedge clk); #2;
    start = 1'b0;
    for (i = 0; i < 50 && exp_q.size() != 2; i++) begin
      @(negedge clk); #1;
    end
    check("rst_reach_beat2", exp_q.size(), 2);
    @(posedge clk); #2;
    mon_en = 1'b0;
    exp_q.delete();
    resetn = 1'b0;
    @(posedge clk); #2;
    resetn = 1'b1;
    check("midrst_tvalid", tvalid, 1'b0);
    check("midrst_pkts", pkts_sent, 16'd0);
    check("midrst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("midrst_quiet", tvalid, 1'b0);
    mon_en = 1'b1;
    run_burst(130, 1, 0, 0);

    for (int k = 0; k < 12; k++)
      run_burst($urandom_range(0, 300), $urandom_range(0, 4), $urandom_range(0, 5),
                $urandom_range(0, 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
